mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, 16, data word width in bits.
REQ-002 Parameter ADDR_W, 16, word address width in bits.
REQ-003 Parameter WAIT_CYCLES, 2, SRAM access cycles per transaction; legal range 1..15.
REQ-004 Parameter MEM_WORDS, 4096, number of implemented words; addresses >= MEM_WORDS are out of range.
REQ-005 Port clk  input  1  clock; all state updates on rising edge.
REQ-006 Port reset  input  1  reset, asynchronous, active-high.
REQ-007 Port req_valid  input  1  request present from the control unit.
REQ-008 Port req_ready  output  1  responder can accept a request this cycle.
REQ-009 Port req_write  input  1  1 = store, 0 = load or fetch.
REQ-010 Port req_addr  input  ADDR_W  word address.
REQ-011 Port req_wdata  input  DATA_W  store data.
REQ-012 Port rsp_valid  output  1  response available.
REQ-013 Port rsp_ready  input  1  control unit accepts the response this cycle.
REQ-014 Port rsp_rdata  output  DATA_W  load data, or echoed store data for writes.
REQ-015 Port rsp_err  output  1  out-of-range address; qualified by rsp_valid.
REQ-016 Port sram_en  output  1  SRAM access strobe.
REQ-017 Port sram_we  output  1  SRAM write enable; qualified by sram_en.
REQ-018 Port sram_addr  output  ADDR_W  SRAM address.
REQ-019 Port sram_wdata  output  DATA_W  SRAM write data.
REQ-020 Port sram_rdata  input  DATA_W  SRAM read data, valid on the last access cycle.
REQ-021 Port txn_count  output  8  count of completed handshaken responses.

Function
REQ-022 FSM states: IDLE, ACCESS, RESP; all outputs are registered or decoded from state and captured registers only.
REQ-023 IDLE: req_ready=1, all other strobes 0; on req_valid=1 at an edge, capture req_write, req_addr and req_wdata.
REQ-024 Captured address < MEM_WORDS -> ACCESS with the wait counter loaded to WAIT_CYCLES-1.
REQ-025 Captured address >= MEM_WORDS -> RESP directly; rsp_err=1, rsp_rdata=0, no SRAM strobe at any time.
REQ-026 ACCESS: req_ready=0, sram_en=1, sram_we=captured write, sram_addr/sram_wdata held at captured values for every access cycle.
REQ-027 ACCESS: counter decrements each edge; at the edge where counter=0, latch sram_rdata (reads) or captured wdata (writes) into rsp_rdata and enter RESP.
REQ-028 Latency: rsp_valid rises exactly WAIT_CYCLES edges after the accepting edge (1 edge for out-of-range addresses).
REQ-029 RESP: rsp_valid=1, req_ready=0; rsp_rdata and rsp_err stable until handshake.
REQ-030 RESP with rsp_ready=1 at an edge -> IDLE and txn_count increments by 1, wrapping 255 -> 0.
REQ-031 RESP with rsp_ready=0 -> remain in RESP indefinitely; no timeout.
REQ-032 req_valid outside IDLE is ignored; it is not queued.
REQ-033 Minimum spacing between accepted requests is WAIT_CYCLES+2 cycles, because one IDLE cycle always follows RESP.
REQ-034 rsp_ready while rsp_valid=0 has no effect.

Reset
REQ-035 While reset=1, the FSM is in IDLE: req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, txn_count=0, counter=0.
REQ-036 Reset asserted mid-ACCESS drops sram_en and sram_we in the same cycle, without waiting for a clock edge; the transaction is discarded and no response is produced.
REQ-037 After reset deasserts, the first rising edge with req_valid=1 is accepted.

Verification
REQ-038 Read at addr 0x0010, WAIT_CYCLES=2, sram_rdata=0xBEEF -> sram_en high 2 cycles with we=0; rsp_valid 2 edges after accept; rsp_rdata=0xBEEF, rsp_err=0.
REQ-039 Write 0x1234 to 0x0020 -> sram_we=1 for 2 cycles with sram_wdata=0x1234; response carries rsp_rdata=0x1234, rsp_err=0; txn_count 0 -> 1.
REQ-040 Read at addr 0x1000 (=MEM_WORDS) -> no sram_en pulse; rsp_valid after 1 edge; rsp_err=1, rsp_rdata=0.
REQ-041 rsp_ready held 0 for 5 cycles in RESP, with req_valid=1 throughout -> rsp_valid and rsp_rdata stable, req_ready=0, no second capture; after rsp_ready=1, one IDLE cycle, then the pending request is accepted.
REQ-042 Reset pulsed in the 1st ACCESS cycle -> sram_en=0 immediately; rsp_valid never asserts; txn_count=0.
REQ-043 256 back-to-back completed transactions -> txn_count wraps to 0.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port SRAM responder: accepts one request at a time,
// runs a fixed-length SRAM access, then holds the response until taken.
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_WORDS   = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [7:0]        txn_count
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // One extra bit so MEM_WORDS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] MEM_LIM  = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [3:0]      CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [7:0]        txn_q, txn_d;

    // Next-state logic: capture in IDLE, count down in ACCESS, wait in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        txn_d   = txn_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if ({1'b0, req_addr} < MEM_LIM) begin
                        state_d = ACCESS;
                        cnt_d   = CNT_INIT;
                    end else begin
                        // Out of range: skip the SRAM entirely.
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = wr_q ? wdata_q : sram_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    txn_d   = txn_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-transaction registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            txn_q   <= txn_d;
        end
    end

    // SRAM strobes are decoded from state, so reset drops them at once.
    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign sram_en    = (state_q == ACCESS);
    assign sram_we    = sram_en & wr_q;
    assign sram_addr  = sram_en ? addr_q : '0;
    assign sram_wdata = sram_en ? wdata_q : '0;
    assign txn_count  = txn_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with default parameters
// (WAIT_CYCLES=2, MEM_WORDS=4096).
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        sram_en;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;
    logic [7:0]  txn_count;

    int passed;
    int total;

    mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .txn_count  (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #7;
        total++;
        if ({req_ready, rsp_valid, rsp_err, sram_en, sram_we} !== 5'b10000)
            $display("FAIL rst_strobes got %b want 10000",
                     {req_ready, rsp_valid, rsp_err, sram_en, sram_we});
        else passed++;
        total++;
        if ({rsp_rdata, sram_addr, sram_wdata, txn_count} !== 56'd0)
            $display("FAIL rst_data got %h want 0",
                     {rsp_rdata, sram_addr, sram_wdata, txn_count});
        else passed++;
        #5 reset = 1'b0;
    endtask

    task automatic test_write();
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = 16'h0020; req_wdata = 16'h1234;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({sram_en, sram_we, sram_addr, sram_wdata, rsp_valid}
                !== {1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0})
                $display("FAIL wr_access%0d got en=%b we=%b a=%h d=%h v=%b",
                         i, sram_en, sram_we, sram_addr, sram_wdata,
                         rsp_valid);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata, sram_en, txn_count}
            !== {1'b1, 1'b0, 16'h1234, 1'b0, 8'd0})
            $display("FAIL wr_resp got v=%b e=%b d=%h en=%b n=%0d",
                     rsp_valid, rsp_err, rsp_rdata, sram_en, txn_count);
        else passed++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, req_ready, txn_count} !== {1'b0, 1'b1, 8'd1})
            $display("FAIL wr_done got v=%b r=%b n=%0d want 0 1 1",
                     rsp_valid, req_ready, txn_count);
        else passed++;
    endtask

    task automatic test_read();
        req_valid = 1'b1; req_write = 1'b0;
        req_addr = 16'h0010; req_wdata = 16'h5555;
        sram_rdata = 16'hBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({sram_en, sram_we, sram_addr, rsp_valid}
                !== {1'b1, 1'b0, 16'h0010, 1'b0})
                $display("FAIL rd_access%0d got en=%b we=%b a=%h v=%b",
                         i, sram_en, sram_we, sram_addr, rsp_valid);
            else passed++;
            @(posedge clk); #1;
        end
        sram_rdata = 16'h0000;
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata, sram_en, req_ready}
            !== {1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0})
            $display("FAIL rd_resp got v=%b e=%b d=%h en=%b r=%b",
                     rsp_valid, rsp_err, rsp_rdata, sram_en, req_ready);
        else passed++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({rsp_valid, txn_count} !== {1'b0, 8'd2})
            $display("FAIL rd_done got v=%b n=%0d want 0 2",
                     rsp_valid, txn_count);
        else passed++;
        // rsp_ready while idle must not disturb anything
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++;
        if ({req_ready, rsp_valid, txn_count} !== {1'b1, 1'b0, 8'd2})
            $display("FAIL rd_idle_ready got r=%b v=%b n=%0d want 1 0 2",
                     req_ready, rsp_valid, txn_count);
        else passed++;
    endtask

    task automatic test_out_of_range();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1000;
        sram_rdata = 16'hDEAD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata, sram_en, sram_we}
            !== {1'b1, 1'b1, 16'h0000, 1'b0, 1'b0})
            $display("FAIL oor_resp got v=%b e=%b d=%h en=%b we=%b",
                     rsp_valid, rsp_err, rsp_rdata, sram_en, sram_we);
        else passed++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++;
        if ({rsp_valid, sram_en, txn_count} !== {1'b0, 1'b0, 8'd3})
            $display("FAIL oor_done got v=%b en=%b n=%0d want 0 0 3",
                     rsp_valid, sram_en, txn_count);
        else passed++;
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0030;
        sram_rdata = 16'h5A5A;
        repeat (3) @(posedge clk);
        #1;
        req_addr = 16'h0040;
        for (int i = 0; i < 5; i++) begin
            sram_rdata = 16'h1111 + 16'(i);
            total++;
            if ({rsp_valid, rsp_rdata, req_ready, sram_en}
                !== {1'b1, 16'h5A5A, 1'b0, 1'b0})
                $display("FAIL bp_hold%0d got v=%b d=%h r=%b en=%b",
                         i, rsp_valid, rsp_rdata, req_ready, sram_en);
            else passed++;
            @(posedge clk); #1;
        end
        total++;
        if ({rsp_valid, rsp_rdata, txn_count} !== {1'b1, 16'h5A5A, 8'd3})
            $display("FAIL bp_still got v=%b d=%h n=%0d",
                     rsp_valid, rsp_rdata, txn_count);
        else passed++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++;
        if ({req_ready, rsp_valid, sram_en, txn_count}
            !== {1'b1, 1'b0, 1'b0, 8'd4})
            $display("FAIL bp_idle got r=%b v=%b en=%b n=%0d",
                     req_ready, rsp_valid, sram_en, txn_count);
        else passed++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        sram_rdata = 16'h7777;
        total++;
        if ({sram_en, sram_addr} !== {1'b1, 16'h0040})
            $display("FAIL bp_accept2 got en=%b a=%h want 1 0040",
                     sram_en, sram_addr);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 16'h7777})
            $display("FAIL bp_resp2 got v=%b d=%h want 1 7777",
                     rsp_valid, rsp_rdata);
        else passed++;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++;
        if (txn_count !== 8'd5)
            $display("FAIL bp_count got %0d want 5", txn_count);
        else passed++;
    endtask

    task automatic test_reset_mid_access();
        logic seen;
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = 16'h0050; req_wdata = 16'hAAAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if ({sram_en, sram_we} !== 2'b11)
            $display("FAIL mr_access got en=%b we=%b want 1 1",
                     sram_en, sram_we);
        else passed++;
        #1 reset = 1'b1;
        #1;
        total++;
        if ({sram_en, sram_we, txn_count} !== {1'b0, 1'b0, 8'd0})
            $display("FAIL mr_async got en=%b we=%b n=%0d want 0 0 0",
                     sram_en, sram_we, txn_count);
        else passed++;
        @(posedge clk); #2;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid | sram_en;
        end
        total++;
        if ({seen, req_ready, txn_count} !== {1'b0, 1'b1, 8'd0})
            $display("FAIL mr_discard got seen=%b r=%b n=%0d want 0 1 0",
                     seen, req_ready, txn_count);
        else passed++;
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0001;
        rsp_ready = 1'b1;
        sram_rdata = 16'h0F0F;
        repeat (4 * 255) @(posedge clk);
        #1;
        total++;
        if ({txn_count, req_ready} !== {8'd255, 1'b1})
            $display("FAIL b2b_255 got n=%0d r=%b want 255 1",
                     txn_count, req_ready);
        else passed++;
        repeat (4) @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        total++;
        if (txn_count !== 8'd0)
            $display("FAIL b2b_wrap got n=%0d want 0", txn_count);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        sram_rdata = '0;
        test_reset();
        test_write();
        test_read();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_access();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
